// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Bundles the hazard inputs and pipeline-enable outputs of the central
// stall/flush sequencer.
//   master : pipeline side. Drives the hazard/memory status and receives the
//            register enables.
//   slave  : sequencer side. Receives the status and drives the enables,
//            the timeout flag and the stall counter.
// Signals:
//   IDEXMemRead, IDEXrd        load in EX and its destination register
//   IFIDrs1, IFIDrs2           source registers of the instruction in ID
//   branch_taken               taken branch/jump resolved in EX (pulse)
//   dmem_req, dmem_ready       data-memory access issued / completing
//   PCWrite, IFIDWrite         PC and IF/ID load enables
//   IFIDFlush                  IF/ID loads a NOP
//   mux_control                0 = ID/EX loads a bubble
//   EXMEMWrite                 EX/MEM and MEM/WB load enable
//   mem_timeout                sticky data-memory timeout error
//   stall_cycles               saturating count of cycles with PCWrite==0
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             IDEXMemRead;
    logic [4:0]       IDEXrd;
    logic [4:0]       IFIDrs1;
    logic [4:0]       IFIDrs2;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             mux_control;
    logic             EXMEMWrite;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output IDEXMemRead, IDEXrd, IFIDrs1, IFIDrs2,
               branch_taken, dmem_req, dmem_ready,
        input  PCWrite, IFIDWrite, IFIDFlush, mux_control,
               EXMEMWrite, mem_timeout, stall_cycles
    );

    modport slave (
        input  IDEXMemRead, IDEXrd, IFIDrs1, IFIDrs2,
               branch_taken, dmem_req, dmem_ready,
        output PCWrite, IFIDWrite, IFIDFlush, mux_control,
               EXMEMWrite, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges
// load-use hazard stalls, taken-branch flushes and multi-cycle data-memory
// waits into one set of pipeline-register enables. It also flags a sticky
// memory timeout and counts the cycles in which the PC is held.
// Parameters:
//   TIMEOUT  maximum consecutive dmem wait cycles before the error (>= 2)
//   CNT_W    width of the saturating stall_cycles counter
// Ports:
//   clk      pipeline clock, rising edge
//   rst      asynchronous reset, active-high
//   bus      slave side of pipeline_stall_ctrl_if
// The enables are decoded combinationally from the state and the current
// inputs. This lets a hazard seen in ID stall the pipeline in the same cycle.
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {INIT, RUN, MEM_WAIT, FLUSH, ERR} state_t;

    state_t             state;
    logic               flush_pend;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               timeout_q;
    logic [CNT_W-1:0]   stall_q;

    logic load_use;
    logic mem_miss;
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic mux_ctl;
    logic exmem_wr;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = bus.IDEXMemRead && (bus.IDEXrd != 5'd0) &&
                   ((bus.IDEXrd == bus.IFIDrs1) || (bus.IDEXrd == bus.IFIDrs2));
        mem_miss = bus.dmem_req && !bus.dmem_ready;
    end

    always_comb begin
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_flush = 1'b0;
        mux_ctl    = 1'b1;
        exmem_wr   = 1'b1;
        case (state)
            INIT, FLUSH: begin
                ifid_flush = 1'b1;
                mux_ctl    = 1'b0;
            end
            RUN: begin
                if (mem_miss) begin
                    pc_wr    = 1'b0;
                    ifid_wr  = 1'b0;
                    exmem_wr = 1'b0;
                end else if (bus.branch_taken) begin
                    // The instruction that would have stalled is squashed anyway.
                    ifid_flush = 1'b1;
                    mux_ctl    = 1'b0;
                end else if (load_use) begin
                    pc_wr   = 1'b0;
                    ifid_wr = 1'b0;
                    mux_ctl = 1'b0;
                end
            end
            MEM_WAIT: begin
                // Only the memory side advances on completion. Upstream stays held.
                pc_wr    = 1'b0;
                ifid_wr  = 1'b0;
                exmem_wr = bus.dmem_ready;
            end
            default: begin
                pc_wr    = 1'b0;
                ifid_wr  = 1'b0;
                mux_ctl  = 1'b0;
                exmem_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            flush_pend <= 1'b0;
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            if (!pc_wr && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
            case (state)
                INIT: state <= RUN;
                RUN: begin
                    if (mem_miss) begin
                        // The miss cycle itself is the first wait cycle.
                        wait_cnt <= WAIT_W'(1);
                        // Capture the branch pulse. EX is frozen until memory completes.
                        if (bus.branch_taken)
                            flush_pend <= 1'b1;
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        wait_cnt <= '0;
                        state    <= flush_pend ? FLUSH : RUN;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                FLUSH: begin
                    flush_pend <= 1'b0;
                    state      <= RUN;
                end
                default: state <= ERR;
            endcase
        end
    end

    assign bus.PCWrite      = pc_wr;
    assign bus.IFIDWrite    = ifid_wr;
    assign bus.IFIDFlush    = ifid_flush;
    assign bus.mux_control  = mux_ctl;
    assign bus.EXMEMWrite   = exmem_wr;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Testbench for pipeline_stall_ctrl. Control vectors are packed as
// {PCWrite, IFIDWrite, IFIDFlush, mux_control, EXMEMWrite, mem_timeout}.
// The counter is narrowed so that saturation can be reached in a short run.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;
    localparam int TO = 16;
    localparam int CW = 6;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    localparam logic [5:0] V_INIT  = 6'b111010;
    localparam logic [5:0] V_RUN   = 6'b110110;
    localparam logic [5:0] V_LU    = 6'b000010;
    localparam logic [5:0] V_FLUSH = 6'b111010;
    localparam logic [5:0] V_FRZ   = 6'b000100;
    localparam logic [5:0] V_MRDY  = 6'b000110;
    localparam logic [5:0] V_ERR   = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [CW+5:0] exp_q[$];
    logic [CW+5:0] obs_q[$];

    function automatic logic [5:0] ctl_now();
        return {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.mux_control,
                bus.EXMEMWrite, bus.mem_timeout};
    endfunction

    // Drives one cycle of stimulus and queues the expected response. The
    // observed response is queued at the following falling edge.
    task automatic apply(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic bt, input logic req,
                         input logic rdy, input logic [5:0] exp_ctl);
        @(posedge clk);
        #1;
        bus.IDEXMemRead  = mr;
        bus.IDEXrd       = rd;
        bus.IFIDrs1      = rs1;
        bus.IFIDrs2      = rs2;
        bus.branch_taken = bt;
        bus.dmem_req     = req;
        bus.dmem_ready   = rdy;
        exp_q.push_back({exp_ctl, exp_cnt});
        @(negedge clk);
        obs_q.push_back({ctl_now(), bus.stall_cycles});
        if (!exp_ctl[5] && exp_cnt != CMAX)
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic idle(input logic [5:0] exp_ctl);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp_ctl);
    endtask

    task automatic test_reset();
        logic [5:0] c;
        logic [CW+5:0] e, o;
        int idx;
        rst = 1'b1;
        bus.IDEXMemRead = 1'b0; bus.IDEXrd = '0; bus.IFIDrs1 = '0; bus.IFIDrs2 = '0;
        bus.branch_taken = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        c = ctl_now();
        checks++;
        if (c !== V_INIT || bus.stall_cycles !== '0) begin
            errors++;
            $display("FAIL reset_hold: got ctl=%b cnt=%0d, expected ctl=%b cnt=0",
                     c, bus.stall_cycles, V_INIT);
        end
        exp_cnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back({V_INIT, exp_cnt});
        @(negedge clk);
        obs_q.push_back({ctl_now(), bus.stall_cycles});
        idle(V_RUN);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
    endtask

    task automatic test_load_use();
        logic [CW+5:0] e, o;
        int idx;
        apply(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, V_LU);   // rs1 hazard
        idle(V_RUN);
        apply(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, V_LU);   // rs2 hazard
        apply(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, V_LU);   // held two cycles
        apply(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, V_RUN);  // not a load
        apply(1'b1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, V_RUN);  // no match
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
    endtask

    task automatic test_load_x0();
        logic [CW+5:0] e, o;
        int idx;
        apply(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN);
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_RUN);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_x0[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
    endtask

    task automatic test_branch_load_use();
        logic [CW+5:0] e, o;
        int idx;
        apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, V_FLUSH);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, V_FLUSH); // hit does not freeze
        idle(V_RUN);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch_lu[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
    endtask

    task automatic test_mem_wait();
        logic [CW+5:0] e, o;
        int idx;
        logic [CW-1:0] start_cnt;
        start_cnt = exp_cnt;
        repeat (3) apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_FRZ);
        apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, V_MRDY);  // load-use ignored
        idle(V_RUN);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
        checks++;
        if (bus.stall_cycles !== start_cnt + CW'(4)) begin
            errors++;
            $display("FAIL mem_wait_cnt: got %0d, expected %0d",
                     bus.stall_cycles, start_cnt + CW'(4));
        end
    endtask

    task automatic test_branch_mem();
        logic [CW+5:0] e, o;
        int idx;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, V_FRZ);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, V_FRZ);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, V_MRDY);
        idle(V_FLUSH);
        idle(V_RUN);
        idle(V_RUN);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch_mem[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
    endtask

    task automatic test_timeout();
        logic [CW+5:0] e, o;
        logic [5:0] c;
        int idx;
        for (int i = 0; i < TO; i++)
            apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_FRZ);
        repeat (3) apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, V_ERR);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
        // Reset in the middle of a cycle must take effect without a clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 c = ctl_now();
        checks++;
        if (c !== V_INIT || bus.stall_cycles !== '0) begin
            errors++;
            $display("FAIL err_async_rst: got ctl=%b cnt=%0d, expected ctl=%b cnt=0",
                     c, bus.stall_cycles, V_INIT);
        end
        exp_cnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b0;
        exp_q.push_back({V_INIT, exp_cnt});
        @(negedge clk);
        obs_q.push_back({ctl_now(), bus.stall_cycles});
        idle(V_RUN);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_rst[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
    endtask

    task automatic test_saturation();
        logic [CW+5:0] e, o;
        int idx;
        for (int i = 0; i < TO; i++)
            apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_FRZ);
        for (int i = 0; i < 52; i++)
            apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_ERR);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL saturate[%0d]: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         idx, o[CW+5:CW], o[CW-1:0], e[CW+5:CW], e[CW-1:0]);
            end
            idx++;
        end
        @(negedge clk);
        checks++;
        if (bus.stall_cycles !== CMAX) begin
            errors++;
            $display("FAIL saturate_final: got %0d, expected %0d", bus.stall_cycles, CMAX);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_x0();
        test_branch_load_use();
        test_mem_wait();
        test_branch_mem();
        test_timeout();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
